ama_riscv_perf_dump: RTL and testbench
======================================

AMA_RISCV_PERF_DUMP -- requirements
Module: ama_riscv_perf_dump

Interface
REQ-001 Parameter HDR_TAG, default 16'hA11A: upper half of the header word.
REQ-002 clk  input  1  core clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a dump; ignored while busy=1.
REQ-005 csr_gnt  input  1  CSR read port free for this block this cycle.
REQ-006 csr_re  output  1  CSR read request, asserted only in read states.
REQ-007 csr_addr  output  12  CSR address of the current read; 12'h000 when csr_re=0.
REQ-008 csr_rdata  input  32  combinational read data, valid in the same cycle as csr_re && csr_gnt.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  consumer accepts the word this cycle.
REQ-011 out_data  output  32  dump word.
REQ-012 out_last  output  1  marks the final word of a dump; qualified by out_valid.
REQ-013 busy  output  1  a dump is in progress, from the cycle after start until DONE.
REQ-014 done  output  1  one-cycle pulse when the final word is accepted.

Function
REQ-015 Dump order SHALL be 23 words:
- header {HDR_TAG, 16'd22}
- then lo,hi for each of: mcycle (0xB00/0xB80), minstret (0xB02/0xB82), mhpmcounter3..8 (0xB03..0xB08 / 0xB83..0xB88)
- then mhpmevent3..8 (0x323..0x328).
REQ-016 FSM states SHALL be IDLE, HDR, RD_HI, RD_LO, RD_HI2, EMIT_LO, EMIT_HI, RD_EV, EMIT_EV, DONE; a 3-bit index selects counter 0..7 or event 0..5.
REQ-017 IDLE with start=1 SHALL go to HDR next cycle; HDR loads the header into the output register and sets out_valid=1.
REQ-018 A read state SHALL advance only in a cycle with csr_re && csr_gnt; otherwise it holds, and csr_addr stays stable.
REQ-019 Torn-read protection:
- RD_HI captures hi_a; RD_LO captures lo; RD_HI2 compares csr_rdata against hi_a.
- On equality, go to EMIT_LO.
- On mismatch, set hi_a=csr_rdata and return to RD_LO; no retry limit.
REQ-020 EMIT_LO presents lo; EMIT_HI presents hi_a. After EMIT_HI, go to RD_HI for the next counter, or to RD_EV after counter 7.
REQ-021 RD_EV captures one event word; EMIT_EV presents it and loops to RD_EV until event 5.
REQ-022 out_last SHALL be 1 only on the event-5 word; its acceptance goes to DONE, which pulses done=1 and returns to IDLE next cycle.
REQ-023 Output register handshake:
- Single-entry register; a word is accepted when out_valid && out_ready.
- While out_valid=1, out_data and out_last SHALL remain stable.
- No CSR read SHALL be issued until the pending word is accepted.
- out_valid deasserts the cycle after acceptance unless a new word is loaded in that cycle.
REQ-024 Back-to-back: acceptance of word N and loading of word N+1 in the same cycle is permitted, with no bubble, for header-to-RD transitions.
REQ-025 csr_re SHALL never assert in IDLE, DONE, HDR or EMIT_* states.
REQ-026 start asserted in the same cycle as done is ignored; a new dump needs start in IDLE.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE and all of the following SHALL be 0: out_valid, out_last, out_data, csr_re, csr_addr, busy, done, index, hi_a, lo.
REQ-028 rst mid-dump SHALL abandon the dump; no further words and no done pulse.

Verification
REQ-029 Counter stub with mcycle=0x0000_0005_FFFF_FFF0, all event regs 0, out_ready=1, csr_gnt=1 -> 23 words in order; header 0xA11A0016; out_last on word 23; done one cycle later.
REQ-030 Stub with mcycle lo wrapping 0xFFFF_FFFF->0 between RD_HI and RD_LO (hi 5->6) -> RD_LO re-issued; emitted pair is lo=0x0, hi=0x6 for that wrap timing; never lo=0 with hi=5.
REQ-031 csr_gnt toggling 1/0 every cycle -> identical word stream to REQ-029; csr_addr stable while ungranted.
REQ-032 out_ready=0 for 10 cycles on word 4 -> out_data stable, csr_re=0 throughout, stream resumes unchanged.
REQ-033 rst asserted after word 7 -> next cycle out_valid=0, busy=0; no done; a fresh start yields the full 23-word dump.
REQ-034 start pulsed while busy=1 -> no effect; exactly one header in the stream.

Source files
------------

// File: rtl/ama_riscv_perf_dump.sv
// rtl/ama_riscv_perf_dump.sv - streams performance counters and event selectors as a 23-word dump
module ama_riscv_perf_dump #(
  parameter logic [15:0] HDR_TAG = 16'hA11A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        csr_gnt,
  output logic        csr_re,
  output logic [11:0] csr_addr,
  input  logic [31:0] csr_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, HDR, RD_HI, RD_LO, RD_HI2, EMIT_LO, EMIT_HI, RD_EV, EMIT_EV, DONE
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  index, index_nx;
  logic [31:0] hi_a, hi_a_nx;
  logic [31:0] lo, lo_nx;
  logic        out_valid_nx, out_last_nx;
  logic [31:0] out_data_nx;

  logic        slot_free;
  logic        rd_state;
  logic        rd_fire;
  logic [11:0] cnt_addr;

  // Output slot can take a new word when empty or when its word leaves this cycle
  assign slot_free = !out_valid || out_ready;
  assign rd_state  = (state == RD_HI) || (state == RD_LO) || (state == RD_HI2) || (state == RD_EV);
  assign csr_re    = rd_state && slot_free;
  assign rd_fire   = csr_re && csr_gnt;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Low-half CSR address of counter 'index': mcycle, minstret, then mhpmcounter3..8
  always_comb begin
    cnt_addr = 12'hB01 + {9'd0, index};
    if (index == 3'd0) cnt_addr = 12'hB00;
    else if (index == 3'd1) cnt_addr = 12'hB02;
  end

  // Read address is held steady for as long as the request waits for a grant
  always_comb begin
    csr_addr = 12'h000;
    if (csr_re) begin
      case (state)
        RD_LO:   csr_addr = cnt_addr;
        RD_EV:   csr_addr = 12'h323 + {9'd0, index};
        default: csr_addr = cnt_addr | 12'h080;
      endcase
    end
  end

  // Next-state, capture registers and output-slot loading
  always_comb begin
    state_nx     = state;
    index_nx     = index;
    hi_a_nx      = hi_a;
    lo_nx        = lo;
    out_valid_nx = out_valid && !out_ready;
    out_data_nx  = out_data;
    out_last_nx  = out_last;
    case (state)
      IDLE: if (start) state_nx = HDR;
      HDR: begin
        out_valid_nx = 1'b1;
        out_data_nx  = {HDR_TAG, 16'd22};
        out_last_nx  = 1'b0;
        index_nx     = 3'd0;
        state_nx     = RD_HI;
      end
      RD_HI: if (rd_fire) begin
        hi_a_nx  = csr_rdata;
        state_nx = RD_LO;
      end
      RD_LO: if (rd_fire) begin
        lo_nx    = csr_rdata;
        state_nx = RD_HI2;
      end
      RD_HI2: if (rd_fire) begin
        // A changed high half means the low half may have wrapped: reread it
        if (csr_rdata == hi_a) begin
          state_nx = EMIT_LO;
        end else begin
          hi_a_nx  = csr_rdata;
          state_nx = RD_LO;
        end
      end
      EMIT_LO: if (slot_free) begin
        out_valid_nx = 1'b1;
        out_data_nx  = lo;
        out_last_nx  = 1'b0;
        state_nx     = EMIT_HI;
      end
      EMIT_HI: if (slot_free) begin
        out_valid_nx = 1'b1;
        out_data_nx  = hi_a;
        out_last_nx  = 1'b0;
        if (index == 3'd7) begin
          index_nx = 3'd0;
          state_nx = RD_EV;
        end else begin
          index_nx = index + 3'd1;
          state_nx = RD_HI;
        end
      end
      RD_EV: if (rd_fire) begin
        lo_nx    = csr_rdata;
        state_nx = EMIT_EV;
      end
      EMIT_EV: begin
        // Final word stays here until it is taken
        if (out_valid && out_last) begin
          if (out_ready) state_nx = DONE;
        end else if (slot_free) begin
          out_valid_nx = 1'b1;
          out_data_nx  = lo;
          out_last_nx  = (index == 3'd5);
          if (index != 3'd5) begin
            index_nx = index + 3'd1;
            state_nx = RD_EV;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      index     <= 3'd0;
      hi_a      <= 32'd0;
      lo        <= 32'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      index     <= index_nx;
      hi_a      <= hi_a_nx;
      lo        <= lo_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      out_last  <= out_last_nx;
    end
  end

endmodule

// File: tb/tb_ama_riscv_perf_dump.sv
// tb/tb_ama_riscv_perf_dump.sv - scoreboard bench for ama_riscv_perf_dump
module tb_ama_riscv_perf_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic        csr_gnt;
  logic        csr_re;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  ama_riscv_perf_dump #(.HDR_TAG(16'hA11A)) dut (
    .clk(clk), .rst(rst), .start(start), .csr_gnt(csr_gnt), .csr_re(csr_re),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit gnt_toggle;
    int stall_word;
    bit wrap;
    bit ev_nz;
    int start_again;
    int exp_b00;
  } case_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc = 0;
  int b00_reads = 0;
  int b80_reads = 0;
  int b80_base = 0;
  bit wrap_mode = 0;
  bit ev_nz = 0;
  logic [32:0] exp_q[$];

  bit          hold = 0;
  logic [31:0] hold_data;
  logic        hold_last;
  bit          wait_addr = 0;
  logic [11:0] prev_addr;
  bit          pend_done = 0;

  // CSR stub: counters, events, and a mcycle that wraps right after its first high read
  always_comb begin
    csr_rdata = 32'hBAD0_0000 | {20'd0, csr_addr};
    if (csr_addr == 12'hB00)
      csr_rdata = wrap_mode ? ((b80_reads != b80_base) ? 32'h0 : 32'hFFFF_FFFF) : 32'hFFFF_FFF0;
    else if (csr_addr == 12'hB80)
      csr_rdata = (wrap_mode && (b80_reads != b80_base)) ? 32'h6 : 32'h5;
    else if (csr_addr == 12'hB02) csr_rdata = 32'hC0DE_0001;
    else if (csr_addr == 12'hB82) csr_rdata = 32'h0000_1001;
    else if (csr_addr >= 12'hB03 && csr_addr <= 12'hB08)
      csr_rdata = 32'hC0DE_0000 + {20'd0, csr_addr - 12'hB01};
    else if (csr_addr >= 12'hB83 && csr_addr <= 12'hB88)
      csr_rdata = 32'h0000_1000 + {20'd0, csr_addr - 12'hB81};
    else if (csr_addr >= 12'h323 && csr_addr <= 12'h328)
      csr_rdata = ev_nz ? (32'hE000_0000 + {20'd0, csr_addr - 12'h322}) : 32'h0;
  end

  // Count granted reads of mcycle halves
  always @(posedge clk) begin
    if (csr_re && csr_gnt && csr_addr == 12'hB00) b00_reads <= b00_reads + 1;
    if (csr_re && csr_gnt && csr_addr == 12'hB80) b80_reads <= b80_reads + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_expected(input bit wrap, input bit evn);
    exp_q.push_back({1'b0, 32'hA11A_0016});
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        exp_q.push_back({1'b0, wrap ? 32'h0 : 32'hFFFF_FFF0});
        exp_q.push_back({1'b0, wrap ? 32'h6 : 32'h5});
      end else begin
        exp_q.push_back({1'b0, 32'hC0DE_0000 + k});
        exp_q.push_back({1'b0, 32'h0000_1000 + k});
      end
    end
    for (int e = 0; e < 6; e++)
      exp_q.push_back({(e == 5), evn ? (32'hE000_0000 + e + 1) : 32'h0});
  endtask

  // One clock: observe at the falling edge, then advance past the rising edge
  task automatic step();
    logic [32:0] e;
    @(negedge clk);
    if (rst) begin
      hold = 0;
      wait_addr = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", out_data, hold_data);
        chk("hold_last", {31'd0, out_last}, {31'd0, hold_last});
      end
      if (wait_addr) chk("addr_stable", {20'd0, csr_addr}, {20'd0, prev_addr});
      if (!csr_re) chk("addr_idle", {20'd0, csr_addr}, 32'd0);
      if (out_valid && !out_ready) chk("re_blocked", {31'd0, csr_re}, 32'd0);
      if (pend_done) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        pend_done = 0;
      end else if (done) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (out_valid && out_ready) begin
        acc++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", out_data, e[31:0]);
          chk("word_last", {31'd0, out_last}, {31'd0, e[32]});
          if (out_last) pend_done = 1;
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      wait_addr = csr_re && !csr_gnt;
      prev_addr = csr_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_case(input case_t c);
    int acc_base, b00_base, stall_left;
    bit got_done;
    wrap_mode = c.wrap;
    ev_nz = c.ev_nz;
    b80_base = b80_reads;
    b00_base = b00_reads;
    acc_base = acc;
    push_expected(c.wrap, c.ev_nz);
    start = 1;
    step();
    start = 0;
    got_done = 0;
    stall_left = 10;
    for (int n = 0; n < 3000 && !got_done; n++) begin
      csr_gnt = c.gnt_toggle ? cyc[0] : 1'b1;
      start = (c.start_again != 0 && n == c.start_again);
      if (c.stall_word > 0 && (acc - acc_base) == c.stall_word - 1 && out_valid && stall_left > 0) begin
        out_ready = 0;
        stall_left--;
      end else begin
        out_ready = 1;
      end
      step();
      if (done) got_done = 1;
    end
    start = 0;
    csr_gnt = 1;
    out_ready = 1;
    chk("done_seen", {31'd0, got_done}, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("word_count", acc - acc_base, 32'd23);
    chk("mcycle_lo_reads", b00_reads - b00_base, c.exp_b00);
    step();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
    exp_q.delete();
  endtask

  case_t cases[6];

  initial begin
    int acc_base;
    cases[0] = '{gnt_toggle: 0, stall_word: 0, wrap: 0, ev_nz: 0, start_again: 0,  exp_b00: 1};
    cases[1] = '{gnt_toggle: 1, stall_word: 0, wrap: 0, ev_nz: 0, start_again: 0,  exp_b00: 1};
    cases[2] = '{gnt_toggle: 0, stall_word: 4, wrap: 0, ev_nz: 1, start_again: 0,  exp_b00: 1};
    cases[3] = '{gnt_toggle: 0, stall_word: 0, wrap: 1, ev_nz: 1, start_again: 0,  exp_b00: 2};
    cases[4] = '{gnt_toggle: 0, stall_word: 0, wrap: 0, ev_nz: 1, start_again: 3,  exp_b00: 1};
    cases[5] = '{gnt_toggle: 1, stall_word: 4, wrap: 1, ev_nz: 1, start_again: 10, exp_b00: 2};

    rst = 1; start = 0; csr_gnt = 1; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_csr_re", {31'd0, csr_re}, 32'd0);
    chk("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 0;
    step();

    for (int i = 0; i < 6; i++) run_case(cases[i]);

    // Reset after the seventh word abandons the dump
    wrap_mode = 0;
    ev_nz = 0;
    acc_base = acc;
    push_expected(0, 0);
    start = 1;
    step();
    start = 0;
    for (int n = 0; n < 500 && (acc - acc_base) < 7; n++) step();
    chk("words_before_rst", acc - acc_base, 32'd7);
    rst = 1;
    out_ready = 0;
    step();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst = 0;
    out_ready = 1;
    exp_q.delete();
    for (int n = 0; n < 20; n++) begin
      step();
      chk("quiet_after_rst", {30'd0, out_valid, done}, 32'd0);
    end
    run_case(cases[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
